// File: rtl/shared_alu_sched_if.sv
// rtl/shared_alu_sched_if.sv - start/done handshake and operand/result bundle for shared_alu_sched
interface shared_alu_sched_if #(
    parameter int DATAWIDTH = 64,
    parameter int OUTWIDTH  = 32
);
    logic                 start;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] c;
    logic                 busy;
    logic                 done;
    logic [OUTWIDTH-1:0]  x;
    logic [OUTWIDTH-1:0]  z;

    modport master (
        output start, a, b, c,
        input  busy, done, x, z
    );

    modport slave (
        input  start, a, b, c,
        output busy, done, x, z
    );
endinterface

// File: rtl/shared_alu_sched.sv
// rtl/shared_alu_sched.sv - five-step scheduled compare-select-shift on one shared add/sub unit
module shared_alu_sched #(
    parameter int DATAWIDTH = 64,
    parameter int OUTWIDTH  = 32
) (
    input  logic               clk,
    input  logic               rst,
    shared_alu_sched_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADD_D   = 3'd1,
        ADD_E   = 3'd2,
        SUB_CMP = 3'd3,
        SEL     = 3'd4,
        SHIFT   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t state, state_next;

    logic [DATAWIDTH-1:0] ra, rb, rc, rd, re, rf, rg, rh;
    logic                 rlt, req;
    logic [OUTWIDTH-1:0]  x_q, z_q;
    logic                 busy_c, done_c;

    logic [DATAWIDTH-1:0] alu_a, alu_b, alu_res;
    logic                 alu_sub;
    logic                 cmp_lt, cmp_eq;
    logic [DATAWIDTH-1:0] g_mux, h_mux;
    logic [DATAWIDTH-1:0] sh_x, sh_z;
    logic                 unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Operand routing into the single add/sub unit, chosen by schedule step
    always_comb begin
        state_next = IDLE;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        alu_a      = ra;
        alu_b      = rb;
        alu_sub    = 1'b0;
        case (state)
            IDLE:    state_next = bus.start ? ADD_D : IDLE;
            ADD_D: begin
                state_next = ADD_E;
                busy_c     = 1'b1;
            end
            ADD_E: begin
                state_next = SUB_CMP;
                busy_c     = 1'b1;
                alu_b      = rc;
            end
            SUB_CMP: begin
                state_next = SEL;
                busy_c     = 1'b1;
                alu_sub    = 1'b1;
            end
            SEL: begin
                state_next = SHIFT;
                busy_c     = 1'b1;
            end
            SHIFT: begin
                state_next = DONE;
                busy_c     = 1'b1;
            end
            DONE: begin
                state_next = IDLE;
                done_c     = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign alu_res = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    assign cmp_lt  = (rd < re);
    assign cmp_eq  = (rd == re);
    assign g_mux   = rlt ? rd : re;
    assign h_mux   = req ? g_mux : rf;
    assign sh_x    = rh << rlt;
    assign sh_z    = rg >> req;
    assign unused_bits = ^{sh_x[DATAWIDTH-1:OUTWIDTH], sh_z[DATAWIDTH-1:OUTWIDTH]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ra  <= '0;
            rb  <= '0;
            rc  <= '0;
            rd  <= '0;
            re  <= '0;
            rf  <= '0;
            rg  <= '0;
            rh  <= '0;
            rlt <= 1'b0;
            req <= 1'b0;
            x_q <= '0;
            z_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ra <= bus.a;
                        rb <= bus.b;
                        rc <= bus.c;
                    end
                end
                ADD_D:   rd <= alu_res;
                ADD_E:   re <= alu_res;
                SUB_CMP: begin
                    rf  <= alu_res;
                    rlt <= cmp_lt;
                    req <= cmp_eq;
                end
                SEL: begin
                    rg <= g_mux;
                    rh <= h_mux;
                end
                SHIFT: begin
                    x_q <= sh_x[OUTWIDTH-1:0];
                    z_q <= sh_z[OUTWIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.x    = x_q;
    assign bus.z    = z_q;
endmodule

// File: tb/tb_shared_alu_sched.sv
// tb/tb_shared_alu_sched.sv - directed self-checking bench for shared_alu_sched
module tb_shared_alu_sched;
    localparam int DW = 64;
    localparam int OW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    shared_alu_sched_if #(.DATAWIDTH(DW), .OUTWIDTH(OW)) bus ();

    shared_alu_sched #(.DATAWIDTH(DW), .OUTWIDTH(OW)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept on the first edge, then walk through the fixed latency checking every cycle
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [31:0] ex, input logic [31:0] ez);
        bus.a = a; bus.b = b; bus.c = c; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check({tag, "_busy_mid"}, {63'd0, bus.busy}, 64'd1);
            check({tag, "_done_mid"}, {63'd0, bus.done}, 64'd0);
            step();
        end
        check({tag, "_busy_mid"}, {63'd0, bus.busy}, 64'd1);
        step();
        check({tag, "_done"}, {63'd0, bus.done}, 64'd1);
        check({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
        check({tag, "_x"}, {32'd0, bus.x}, {32'd0, ex});
        check({tag, "_z"}, {32'd0, bus.z}, {32'd0, ez});
        step();
        check({tag, "_done_fall"}, {63'd0, bus.done}, 64'd0);
        check({tag, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        int ndone;
        int first_done;
        int second_done;
        bus.start = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0;
        #2;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_x", {32'd0, bus.x}, 64'd0);
        check("rst_z", {32'd0, bus.z}, 64'd0);
        step();
        step();
        rst_n = 1'b1;

        run_op("lt", 64'd5, 64'd3, 64'd10, 32'd4, 32'd8);
        run_op("eq", 64'd4, 64'd6, 64'd6, 32'd10, 32'd5);
        run_op("borrow", 64'd1, 64'd9, 64'd2, 32'hFFFF_FFF8, 32'd3);
        run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'hFFFF_FFFC, 32'd0);

        // start pulsed while busy and operands changed after accept
        bus.a = 64'd5; bus.b = 64'd3; bus.c = 64'd10; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a = 64'd77; bus.b = 64'd1234; bus.c = 64'd9;
        ndone = 0;
        for (int i = 1; i <= 10; i++) begin
            bus.start = (i == 2);
            if (bus.done) ndone++;
            step();
        end
        bus.start = 1'b0;
        check("robust_x", {32'd0, bus.x}, 64'd4);
        check("robust_z", {32'd0, bus.z}, 64'd8);
        check("robust_ndone", ndone, 64'd1);

        // start held for 14 edges: accepts on edges 1 and 8, dones after edges 6 and 13
        bus.a = 64'd4; bus.b = 64'd6; bus.c = 64'd6; bus.start = 1'b1;
        ndone = 0; first_done = 0; second_done = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (ndone == 1) first_done = i;
                if (ndone == 2) second_done = i;
            end
        end
        check("held_ndone", ndone, 64'd2);
        check("held_first", first_done, 64'd6);
        check("held_gap", second_done - first_done, 64'd7);
        check("held_x", {32'd0, bus.x}, 64'd10);

        // asynchronous reset during SUB_CMP abandons the computation
        bus.a = 64'd1; bus.b = 64'd9; bus.c = 64'd2; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #2;
        check("midrst_x", {32'd0, bus.x}, 64'd0);
        check("midrst_z", {32'd0, bus.z}, 64'd0);
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (bus.done) ndone++;
        end
        check("midrst_nodone", ndone, 64'd0);
        run_op("after_rst", 64'd1, 64'd9, 64'd2, 32'hFFFF_FFF8, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
